// File: rtl/method_pipe_ser.sv
// Per-channel method call holding registers feeding a round-robin serializer that
// streams each call as a fixed number of pipe beats: a header, then the payload.
module method_pipe_ser #(
    parameter int NCHAN      = 4,
    parameter int ARG_WIDTH  = 96,
    parameter int PIPE_WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NCHAN-1:0]           method__ENA,
    input  logic [NCHAN*ARG_WIDTH-1:0] method_v,
    output logic [NCHAN-1:0]           method__RDY,
    output logic                       pipe_enq__ENA,
    output logic [PIPE_WIDTH-1:0]      pipe_enq_v,
    input  logic                       pipe_enq__RDY,
    output logic [15:0]                sent_count
);

    localparam int BEATS     = (ARG_WIDTH + 16 + PIPE_WIDTH - 1) / PIPE_WIDTH;
    localparam int MSG_WIDTH = BEATS * PIPE_WIDTH;
    localparam int CHAN_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NCHAN-1:0]       valid;
    logic [ARG_WIDTH-1:0]   hold [NCHAN];
    logic [CHAN_W-1:0]      last_grant;
    logic [CHAN_W-1:0]      grant_idx;
    logic [CHAN_W-1:0]      cand;
    logic                   grant_found;
    logic [MSG_WIDTH-1:0]   shift_reg;
    logic [MSG_WIDTH-1:0]   load_word;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   xfer;
    logic                   last_beat;
    logic                   load;

    assign xfer      = (state == SEND) && pipe_enq__RDY;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

    // Round-robin search begins just past the previous winner and wraps around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NCHAN; k++) begin
            cand = CHAN_W'((int'(last_grant) + k) % NCHAN);
            if (!grant_found && valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Header occupies the low 16 bits so it leaves in beat 0.
    always_comb begin
        load_word                   = '0;
        load_word[7:0]              = 8'(BEATS);
        load_word[15:8]             = 8'(grant_idx);
        load_word[16 +: ARG_WIDTH]  = hold[grant_idx];
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer && last_beat) begin
                    if (grant_found) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            shift_reg  <= '0;
            beat_cnt   <= '0;
            last_grant <= CHAN_W'(NCHAN - 1);
            sent_count <= '0;
        end else begin
            if (load) begin
                shift_reg  <= load_word;
                beat_cnt   <= '0;
                last_grant <= grant_idx;
            end else if (xfer) begin
                shift_reg <= shift_reg >> PIPE_WIDTH;
                beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (xfer && last_beat) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    // A channel can only be granted while valid, so clear and capture never collide.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            valid <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (load && (grant_idx == CHAN_W'(i))) begin
                    valid[i] <= 1'b0;
                end else if (method__ENA[i] && !valid[i]) begin
                    valid[i] <= 1'b1;
                    hold[i]  <= method_v[i*ARG_WIDTH +: ARG_WIDTH];
                end
            end
        end
    end

    assign method__RDY   = ~valid;
    assign pipe_enq__ENA = xfer;
    assign pipe_enq_v    = (state == SEND) ? shift_reg[PIPE_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_method_pipe_ser.sv
// Scoreboard bench for method_pipe_ser: expected beats are queued when calls are made
// and compared as the pipe emits them; a single-beat instance covers counter wrap.
module tb_method_pipe_ser;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   m_ena;
    logic [383:0] m_v;
    logic [3:0]   m_rdy;
    logic         p_ena;
    logic [31:0]  p_v;
    logic         p_rdy;
    logic [15:0]  sent;

    logic [1:0]   w_ena;
    logic [191:0] w_v;
    logic [1:0]   w_rdy;
    logic         w_p_ena;
    logic [127:0] w_p_v;
    logic [15:0]  w_sent;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  mon_exp;

    always #5 clk = ~clk;

    method_pipe_ser #(.NCHAN(4), .ARG_WIDTH(96), .PIPE_WIDTH(32)) dut (
        .CLK(clk), .nRST(rst),
        .method__ENA(m_ena), .method_v(m_v), .method__RDY(m_rdy),
        .pipe_enq__ENA(p_ena), .pipe_enq_v(p_v), .pipe_enq__RDY(p_rdy),
        .sent_count(sent)
    );

    method_pipe_ser #(.NCHAN(2), .ARG_WIDTH(96), .PIPE_WIDTH(128)) dut_wrap (
        .CLK(clk), .nRST(rst),
        .method__ENA(w_ena), .method_v(w_v), .method__RDY(w_rdy),
        .pipe_enq__ENA(w_p_ena), .pipe_enq_v(w_p_v), .pipe_enq__RDY(1'b1),
        .sent_count(w_sent)
    );

    // Every transferred beat must be the next one the model expects.
    always @(negedge clk) begin
        if (!rst && p_ena) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat got %h required none", p_v);
            end else begin
                mon_exp = exp_q.pop_front();
                if (p_v !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL beat_data got %h required %h", p_v, mon_exp);
                end
            end
        end
    end

    task automatic push_msg(input int ch, input logic [95:0] pl);
        logic [127:0] w;
        w         = '0;
        w[7:0]    = 8'd4;
        w[15:8]   = 8'(ch);
        w[111:16] = pl;
        for (int b = 0; b < 4; b++) exp_q.push_back(w[b*32 +: 32]);
    endtask

    task automatic call(input int ch, input logic [95:0] pl);
        @(posedge clk); #1;
        m_ena[ch]          = 1'b1;
        m_v[ch*96 +: 96]   = pl;
        @(posedge clk); #1;
        m_ena = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst   = 1'b1;
        m_ena = '0;
        w_ena = '0;
        p_rdy = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ena(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p_ena) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !p_ena) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (m_rdy !== 4'hF) begin errors++; $display("[TB] FAIL reset_rdy got %b required 1111", m_rdy); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL reset_ena got %b required 0", p_ena); end
        if (p_v !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h required 0", p_v); end
        if (sent !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got %h required 0", sent); end
        if (w_rdy !== 2'b11) begin errors++; $display("[TB] FAIL reset_wrap_rdy got %b required 11", w_rdy); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        exp_q.push_back(32'h44440204);
        exp_q.push_back(32'h22223333);
        exp_q.push_back(32'h11112222);
        exp_q.push_back(32'h00001111);
        call(2, 96'h111111112222222233334444);
        @(negedge clk);
        checks += 2;
        if (m_rdy !== 4'b1011) begin errors++; $display("[TB] FAIL single_rdy got %b required 1011", m_rdy); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL single_early got %b required 0", p_ena); end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p_ena) n++;
        end
        @(negedge clk);
        checks += 4;
        if (n != 4) begin errors++; $display("[TB] FAIL single_contig got %0d required 4", n); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got %b required 0", p_ena); end
        if (sent !== 16'd1) begin errors++; $display("[TB] FAIL single_count got %0d required 1", sent); end
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL single_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_multi();
        logic [95:0] pl [4];
        int n;
        do_reset();
        for (int c = 0; c < 4; c++) pl[c] = {$urandom, $urandom, $urandom};
        push_msg(0, pl[0]);
        push_msg(1, pl[1]);
        push_msg(3, pl[3]);
        @(posedge clk); #1;
        m_ena = 4'b1011;
        for (int c = 0; c < 4; c++) m_v[c*96 +: 96] = pl[c];
        @(posedge clk); #1;
        m_ena = '0;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (p_ena) n++;
        end
        @(negedge clk);
        checks += 3;
        if (n != 12) begin errors++; $display("[TB] FAIL multi_contig got %0d required 12", n); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL multi_idle got %b required 0", p_ena); end
        if (sent !== 16'd3) begin errors++; $display("[TB] FAIL multi_count got %0d required 3", sent); end
    endtask

    task automatic test_stall();
        logic [95:0] pl;
        logic [31:0] b2;
        bit ok;
        do_reset();
        pl = {$urandom, $urandom, $urandom};
        push_msg(0, pl);
        b2 = exp_q[2];
        call(0, pl);
        wait_ena(ok);
        @(negedge clk);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL stall_start got timeout required beat"); end
        if (p_ena !== 1'b1) begin errors++; $display("[TB] FAIL stall_beat1 got %b required 1", p_ena); end
        @(posedge clk); #1;
        p_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 2;
            if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL stall_ena got %b required 0", p_ena); end
            if (p_v !== b2) begin errors++; $display("[TB] FAIL stall_hold got %h required %h", p_v, b2); end
        end
        @(posedge clk); #1;
        p_rdy = 1'b1;
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL stall_drain got timeout required drained"); end
        if (sent !== 16'd1) begin errors++; $display("[TB] FAIL stall_count got %0d required 1", sent); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] pa, pb, pc;
        bit ok;
        int n;
        do_reset();
        p_rdy = 1'b0;
        pa = {$urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom};
        pc = {$urandom, $urandom, $urandom};
        push_msg(1, pa);
        push_msg(1, pb);
        call(1, pa);
        call(1, pb);
        @(negedge clk);
        checks++;
        if (m_rdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy_held got %b required 0", m_rdy[1]); end
        call(1, pc);
        @(negedge clk);
        checks += 2;
        if (m_rdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy_ignored got %b required 0", m_rdy[1]); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stalled got %b required 0", p_ena); end
        p_rdy = 1'b1;
        wait_drain(ok);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (p_ena) n++;
        end
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL b2b_drain got timeout required drained"); end
        if (sent !== 16'd2) begin errors++; $display("[TB] FAIL b2b_count got %0d required 2", sent); end
        if (n != 0) begin errors++; $display("[TB] FAIL b2b_extra got %0d required 0", n); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] pl;
        bit ok;
        int n;
        do_reset();
        pl = {$urandom, $urandom, $urandom};
        push_msg(0, pl);
        call(0, pl);
        wait_ena(ok);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks += 5;
        if (!ok) begin errors++; $display("[TB] FAIL rmid_start got timeout required beat"); end
        if (p_ena !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ena got %b required 0", p_ena); end
        if (m_rdy !== 4'hF) begin errors++; $display("[TB] FAIL rmid_rdy got %b required 1111", m_rdy); end
        if (sent !== 16'h0) begin errors++; $display("[TB] FAIL rmid_count got %0d required 0", sent); end
        if (p_v !== 32'h0) begin errors++; $display("[TB] FAIL rmid_data got %h required 0", p_v); end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p_ena) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("[TB] FAIL rmid_leftover got %0d required 0", n); end
        pl = {$urandom, $urandom, $urandom};
        push_msg(3, pl);
        call(3, pl);
        wait_ena(ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL rmid_ch3 got timeout required beat"); end
        if (p_v[15:0] !== 16'h0304) begin errors++; $display("[TB] FAIL rmid_header got %h required 0304", p_v[15:0]); end
        wait_drain(ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL rmid_drain got timeout required drained"); end
        if (sent !== 16'd1) begin errors++; $display("[TB] FAIL rmid_count2 got %0d required 1", sent); end
    endtask

    task automatic test_wrap();
        logic [95:0] pl0, pl1;
        int beats;
        bit first;
        do_reset();
        pl0   = {$urandom, $urandom, $urandom};
        pl1   = {$urandom, $urandom, $urandom};
        w_v   = {pl1, pl0};
        w_ena = 2'b11;
        beats = 0;
        first = 1'b1;
        for (int i = 0; i < 70000 && beats < 65530; i++) begin
            @(negedge clk);
            if (w_p_ena) begin
                if (first) begin
                    checks++;
                    if (w_p_v !== {16'h0, pl0, 8'h00, 8'h01}) begin
                        errors++;
                        $display("[TB] FAIL wrap_first got %h required %h", w_p_v, {16'h0, pl0, 8'h00, 8'h01});
                    end
                    first = 1'b0;
                end
                beats++;
            end
        end
        w_ena = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_p_ena) beats++;
        end
        for (int i = 0; i < 100 && beats < 65537; i++) begin
            w_ena = 2'b01;
            @(negedge clk);
            w_ena = 2'b00;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (w_p_ena) beats++;
            end
        end
        checks += 2;
        if (beats != 65537) begin errors++; $display("[TB] FAIL wrap_msgs got %0d required 65537", beats); end
        if (w_sent !== 16'h0001) begin errors++; $display("[TB] FAIL wrap_count got %h required 0001", w_sent); end
    endtask

    initial begin
        m_ena = '0;
        m_v   = '0;
        p_rdy = 1'b1;
        w_ena = '0;
        w_v   = '0;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
